// File: rtl/adam_obi_sram_ctrl.sv
// OBI slave terminating the core's data-RAM port on a single-port SRAM macro.
// Credit-based grant, fixed-latency read pipe, fall-through in-order response FIFO.
module adam_obi_sram_ctrl #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] MEM_BASE = 32'h0200_0000,
   parameter int unsigned MEM_WORDS  = 4096,
   parameter int unsigned READ_LAT   = 1,
   parameter int unsigned RESP_DEPTH = 4,
   localparam int unsigned AW = $clog2(MEM_WORDS),
   localparam int unsigned BW = DATA_WIDTH / 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  req_i,
   output logic                  gnt_o,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic                  we_i,
   input  logic [BW-1:0]         be_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic                  err_o,
   output logic                  sram_req_o,
   output logic                  sram_we_o,
   output logic [AW-1:0]         sram_addr_o,
   output logic [BW-1:0]         sram_be_o,
   output logic [DATA_WIDTH-1:0] sram_wdata_o,
   input  logic [DATA_WIDTH-1:0] sram_rdata_i
);

   localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
   localparam int unsigned PW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(RESP_DEPTH - 1);
   localparam logic [ADDR_WIDTH:0] WIN_BYTES = (ADDR_WIDTH + 1)'(MEM_WORDS) << 2;

   logic [CW-1:0]         r_out;
   logic [CW-1:0]         r_cnt;
   logic [PW-1:0]         r_wptr;
   logic [PW-1:0]         r_rptr;
   logic [READ_LAT-1:0]   r_pv;
   logic [READ_LAT-1:0]   r_pwe;
   logic [READ_LAT-1:0]   r_perr;
   logic [DATA_WIDTH-1:0] r_fdata [RESP_DEPTH];
   logic [RESP_DEPTH-1:0] r_ferr;

   logic [ADDR_WIDTH-1:0] w_off;
   logic                  w_in_range;
   logic                  w_accept;
   logic                  w_sram_req;
   logic                  w_fifo_ne;
   logic                  w_resp_v;
   logic                  w_resp_err;
   logic [DATA_WIDTH-1:0] w_resp_rdata;
   logic                  w_pop;
   logic                  w_push;
   logic                  w_head_pop;

   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? {PW{1'b0}} : p + PW'(1);
   endfunction

   assign w_off      = addr_i - MEM_BASE;
   assign w_in_range = (addr_i >= MEM_BASE) && ({1'b0, w_off} < WIN_BYTES);

   // Grant comes from the credit register alone, so it never loops back from req_i/rready_i
   assign gnt_o      = (r_out < DEPTH_C);
   assign w_accept   = rst_ni & req_i & gnt_o;
   assign w_sram_req = w_accept & w_in_range;

   assign sram_req_o   = w_sram_req;
   assign sram_we_o    = w_sram_req & we_i;
   assign sram_addr_o  = w_off[AW+1:2];
   assign sram_be_o    = (w_sram_req & we_i) ? be_i : {BW{1'b0}};
   assign sram_wdata_o = wdata_i;

   assign w_resp_v     = r_pv[READ_LAT-1];
   assign w_resp_err   = r_perr[READ_LAT-1];
   assign w_resp_rdata = (w_resp_v && !r_pwe[READ_LAT-1] && !w_resp_err) ? sram_rdata_i
                                                                         : {DATA_WIDTH{1'b0}};
   assign w_fifo_ne    = (r_cnt != {CW{1'b0}});

   // Empty FIFO lets the emerging response fall straight through to the outputs
   assign rvalid_o   = w_fifo_ne | w_resp_v;
   assign rdata_o    = w_fifo_ne ? r_fdata[r_rptr] : w_resp_rdata;
   assign err_o      = w_fifo_ne ? r_ferr[r_rptr] : (w_resp_v & w_resp_err);
   assign w_pop      = rvalid_o & rready_i;
   assign w_head_pop = w_fifo_ne & rready_i;
   assign w_push     = w_resp_v & (w_fifo_ne | ~rready_i);

   // Credit counter: one credit per accepted request, returned on response pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_out <= {CW{1'b0}};
      end else begin
         case ({w_accept, w_pop})
            2'b10:   r_out <= r_out + CW'(1);
            2'b01:   r_out <= r_out - CW'(1);
            default: r_out <= r_out;
         endcase
      end
   end

   // Latency pipe of {valid, we, err} aligned with the SRAM read data
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_pv   <= {READ_LAT{1'b0}};
         r_pwe  <= {READ_LAT{1'b0}};
         r_perr <= {READ_LAT{1'b0}};
      end else begin
         for (int i = READ_LAT - 1; i > 0; i--) begin
            r_pv[i]   <= r_pv[i-1];
            r_pwe[i]  <= r_pwe[i-1];
            r_perr[i] <= r_perr[i-1];
         end
         r_pv[0]   <= w_accept;
         r_pwe[0]  <= we_i;
         r_perr[0] <= ~w_in_range;
      end
   end

   // Response FIFO pointers and occupancy
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= {PW{1'b0}};
         r_rptr <= {PW{1'b0}};
         r_cnt  <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_wptr <= f_inc(r_wptr);
         end else begin
            r_wptr <= r_wptr;
         end
         if (w_head_pop) begin
            r_rptr <= f_inc(r_rptr);
         end else begin
            r_rptr <= r_rptr;
         end
         case ({w_push, w_head_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Response FIFO storage; contents are only observable through valid pointers
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_fdata[r_wptr] <= w_resp_rdata;
         r_ferr[r_wptr]  <= w_resp_err;
      end
   end

endmodule
